// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write/readback port of the ROM loader.
interface rom_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        rom_we;
  logic        rom_select;
  logic [5:0]  rom_addr;
  logic [31:0] rom_wd;
  logic [31:0] rom_rd;

  // Loader side: consumes bytes, drives the ROM port.
  modport master (
    input  in_valid, in_data, rom_rd,
    output in_ready, rom_we, rom_select, rom_addr, rom_wd
  );

  // Environment side: byte source and ROM model.
  modport slave (
    output in_valid, in_data, rom_rd,
    input  in_ready, rom_we, rom_select, rom_addr, rom_wd
  );
endinterface

// File: rtl/rom_loader.sv
// Loads a little-endian byte stream into the program or exception ROM,
// holding the CPU while busy, with an optional readback-compare pass.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; cfg_err on illegal word_count
// COLLECT | accepting bytes into the word assembly register
// WRITE   | one-cycle ROM write of the assembled word
// VADDR   | presents rom_addr for readback
// VCMP    | compares rom_rd against the shadow copy
// FINISH  | one-cycle done pulse, then IDLE
module rom_loader #(
  parameter int unsigned VERIFY = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        sel,
  input  logic [6:0]  word_count,
  rom_loader_if.master bus,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        cfg_err,
  output logic        vfy_err,
  output logic [5:0]  vfy_addr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    VADDR   = 3'd3,
    VCMP    = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [5:0]  rom_addr_q, rom_addr_d;
  logic [31:0] rom_wd_q, rom_wd_d;
  logic        sel_q, sel_d;
  logic [6:0]  word_count_q, word_count_d;
  logic        cfg_err_q, cfg_err_d;
  logic        vfy_err_q, vfy_err_d;
  logic [5:0]  vfy_addr_q, vfy_addr_d;

  logic [31:0] shadow_q [64];

  logic cfg_ok;
  logic accept;
  logic byte_acc;
  logic last_word;
  logic mismatch;
  logic in_ready_c;
  logic rom_we_c;

  assign cfg_ok    = (word_count != 7'd0) && (word_count <= 7'd64);
  assign accept    = (state_q == IDLE) && start && cfg_ok;
  assign byte_acc  = in_ready_c && bus.in_valid;
  // rom_addr doubles as the word index in both the load and verify passes
  assign last_word = ({1'b0, rom_addr_q} == (word_count_q - 7'd1));
  assign mismatch  = (bus.rom_rd != shadow_q[rom_addr_q]);

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      rom_addr_q   <= 6'd0;
      rom_wd_q     <= 32'd0;
      sel_q        <= 1'b0;
      word_count_q <= 7'd0;
      cfg_err_q    <= 1'b0;
      vfy_err_q    <= 1'b0;
      vfy_addr_q   <= 6'd0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      rom_addr_q   <= rom_addr_d;
      rom_wd_q     <= rom_wd_d;
      sel_q        <= sel_d;
      word_count_q <= word_count_d;
      cfg_err_q    <= cfg_err_d;
      vfy_err_q    <= vfy_err_d;
      vfy_addr_q   <= vfy_addr_d;
    end
  end

  // Shadow copy of every word written, used by the readback compare
  always_ff @(posedge sys_clk) begin
    if (rom_we_c) begin
      shadow_q[rom_addr_q] <= rom_wd_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = COLLECT;
      COLLECT: if (byte_acc && (byte_cnt_q == 2'd3)) state_d = WRITE;
      WRITE: begin
        if (!last_word)       state_d = COLLECT;
        else if (VERIFY != 0) state_d = VADDR;
        else                  state_d = FINISH;
      end
      VADDR:   state_d = VCMP;
      VCMP:    state_d = last_word ? FINISH : VADDR;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: capture, byte assembly, address stepping, verify flags
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    rom_addr_d   = rom_addr_q;
    rom_wd_d     = rom_wd_q;
    sel_d        = sel_q;
    word_count_d = word_count_q;
    cfg_err_d    = (state_q == IDLE) && start && !cfg_ok;
    vfy_err_d    = vfy_err_q;
    vfy_addr_d   = vfy_addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d        = sel;
          word_count_d = word_count;
          byte_cnt_d   = 2'd0;
          rom_addr_d   = 6'd0;
          vfy_err_d    = 1'b0;
          vfy_addr_d   = 6'd0;
        end
      end
      COLLECT: begin
        if (byte_acc) begin
          rom_wd_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      WRITE: begin
        // last word keeps its address for load-only mode; verify restarts at 0
        if (!last_word)       rom_addr_d = rom_addr_q + 6'd1;
        else if (VERIFY != 0) rom_addr_d = 6'd0;
      end
      VCMP: begin
        if (mismatch && !vfy_err_q) begin
          vfy_err_d  = 1'b1;
          vfy_addr_d = rom_addr_q;
        end
        if (!last_word) rom_addr_d = rom_addr_q + 6'd1;
      end
      default: begin
      end
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready_c = 1'b0;
    rom_we_c   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      IDLE:    busy       = 1'b0;
      COLLECT: in_ready_c = 1'b1;
      WRITE:   rom_we_c   = 1'b1;
      FINISH:  done       = 1'b1;
      default: begin
      end
    endcase
  end

  assign cpu_hold       = busy;
  assign cfg_err        = cfg_err_q;
  assign vfy_err        = vfy_err_q;
  assign vfy_addr       = vfy_addr_q;
  assign bus.in_ready   = in_ready_c;
  assign bus.rom_we     = rom_we_c;
  assign bus.rom_select = sel_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_wd     = rom_wd_q;

endmodule
